// File: rtl/sched_pkg.sv
// Shared definitions for the scheduler datapath: AXI-Stream width defaults
// used by the crossbar and the packet FIFOs, plus the write-side FSM states.
package sched_pkg;

  localparam int SCHED_AXIS_DATA_WIDTH = 64;
  localparam int SCHED_AXIS_KEEP_WIDTH = SCHED_AXIS_DATA_WIDTH / 8;

  // Write-side packet FSM: IDLE between packets, WRITE inside a packet that
  // is still being stored, DROP while discarding the rest of an overflowed one.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DROP  = 2'd2
  } wr_state_e;

  // Width of one stored beat: data, byte enables and the tlast flag.
  function automatic int beat_width(input int data_w, input int keep_w);
    return data_w + keep_w + 1;
  endfunction

endpackage

// File: rtl/sched_fifo_ram.sv
// Simple dual-port RAM for the packet FIFO: one write port and one read port
// whose output is registered, so read data appears the cycle after rd_en.
module sched_fifo_ram #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [WIDTH-1:0] rd_data_q;

  // Write port: store the beat at the write address.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; contents are not reset, validity is tracked outside.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sched_packet_fifo.sv
// Store-and-forward AXI-Stream packet FIFO. The input never backpressures;
// a packet that does not fit is dropped whole. Only fully received packets
// are ever fetched from RAM and presented downstream.
module sched_packet_fifo
  import sched_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = SCHED_AXIS_DATA_WIDTH,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int DEPTH           = 512,
  parameter int ADDR_WIDTH      = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [ADDR_WIDTH:0]        status_depth,
  output logic [ADDR_WIDTH:0]        status_pkt_count,
  output logic                       status_drop
);

  localparam int BEAT_W = beat_width(AXIS_DATA_WIDTH, AXIS_KEEP_WIDTH);

  typedef logic [ADDR_WIDTH:0] ptr_t;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  // wr_ptr        : next RAM slot to write (includes uncommitted beats)
  // wr_ptr_commit : end of the last complete packet
  // fetch_ptr     : next RAM slot to read into the output pipeline
  // rd_ptr        : beats handed downstream; space frees when this advances,
  //                 so beats sitting in the read pipeline still occupy room
  wr_state_e        state_q, state_d;
  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             wr_ptr_commit_q, wr_ptr_commit_d;
  ptr_t             fetch_ptr_q, fetch_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  ptr_t             pkt_count_q, pkt_count_d;
  ptr_t             depth_q, depth_d;
  logic             drop_q, drop_d;
  logic             ram_valid_q, ram_valid_d;
  logic [BEAT_W-1:0] buf0_q, buf0_d;
  logic [BEAT_W-1:0] buf1_q, buf1_d;
  logic             valid0_q, valid0_d;
  logic             valid1_q, valid1_d;

  logic              s_accept;
  logic              fifo_full;
  logic              ram_wr_en;
  logic              ram_rd_en;
  logic              commit;
  logic              out_pop;
  logic              out_last_pop;
  ptr_t              used;
  logic [BEAT_W-1:0] ram_wr_data;
  logic [BEAT_W-1:0] ram_rd_data;

  assign s_axis_tready = ~rst;
  assign s_accept      = s_axis_tvalid & s_axis_tready;
  assign used          = wr_ptr_q - rd_ptr_q;
  assign fifo_full     = (used == ptr_t'(DEPTH));
  assign ram_wr_data   = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};

  sched_fifo_ram #(
    .WIDTH      (BEAT_W),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_wr_en),
    .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wr_data (ram_wr_data),
    .rd_en   (ram_rd_en),
    .rd_addr (fetch_ptr_q[ADDR_WIDTH-1:0]),
    .rd_data (ram_rd_data)
  );

  // Write FSM: store beats, commit on tlast, rewind and discard on overflow.
  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    wr_ptr_commit_d = wr_ptr_commit_q;
    drop_d          = 1'b0;
    ram_wr_en       = 1'b0;
    commit          = 1'b0;
    case (state_q)
      IDLE, WRITE: begin
        if (s_accept) begin
          if (fifo_full) begin
            wr_ptr_d = wr_ptr_commit_q;
            drop_d   = 1'b1;
            state_d  = s_axis_tlast ? IDLE : DROP;
          end else begin
            ram_wr_en = 1'b1;
            wr_ptr_d  = wr_ptr_q + ptr_t'(1);
            if (s_axis_tlast) begin
              wr_ptr_commit_d = wr_ptr_q + ptr_t'(1);
              commit          = 1'b1;
              state_d         = IDLE;
            end else begin
              state_d = WRITE;
            end
          end
        end
      end
      DROP: begin
        if (s_accept && s_axis_tlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output pipeline: a head register driving m_axis plus one skid entry,
  // refilled from the RAM read stage; fetch only when a slot is guaranteed.
  always_comb begin
    buf0_d   = buf0_q;
    buf1_d   = buf1_q;
    valid0_d = valid0_q;
    valid1_d = valid1_q;
    out_pop  = valid0_q & m_axis_tready;
    if (out_pop) begin
      buf0_d   = buf1_q;
      valid0_d = valid1_q;
      valid1_d = 1'b0;
    end
    if (ram_valid_q) begin
      if (!valid0_d) begin
        buf0_d   = ram_rd_data;
        valid0_d = 1'b1;
      end else begin
        buf1_d   = ram_rd_data;
        valid1_d = 1'b1;
      end
    end
    ram_rd_en    = (fetch_ptr_q != wr_ptr_commit_q) && !(valid0_d && valid1_d);
    out_last_pop = out_pop & buf0_q[BEAT_W-1];
  end

  // Read pointers, packet count and registered depth.
  always_comb begin
    fetch_ptr_d = ram_rd_en ? (fetch_ptr_q + ptr_t'(1)) : fetch_ptr_q;
    rd_ptr_d    = out_pop ? (rd_ptr_q + ptr_t'(1)) : rd_ptr_q;
    ram_valid_d = ram_rd_en;
    pkt_count_d = pkt_count_q;
    if (commit && !out_last_pop) begin
      pkt_count_d = pkt_count_q + ptr_t'(1);
    end else if (!commit && out_last_pop) begin
      pkt_count_d = pkt_count_q - ptr_t'(1);
    end
    depth_d = wr_ptr_commit_d - rd_ptr_d;
  end

  // State register; reset discards all stored content.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      wr_ptr_q        <= '0;
      wr_ptr_commit_q <= '0;
      fetch_ptr_q     <= '0;
      rd_ptr_q        <= '0;
      pkt_count_q     <= '0;
      depth_q         <= '0;
      drop_q          <= 1'b0;
      ram_valid_q     <= 1'b0;
      buf0_q          <= '0;
      buf1_q          <= '0;
      valid0_q        <= 1'b0;
      valid1_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      wr_ptr_commit_q <= wr_ptr_commit_d;
      fetch_ptr_q     <= fetch_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      pkt_count_q     <= pkt_count_d;
      depth_q         <= depth_d;
      drop_q          <= drop_d;
      ram_valid_q     <= ram_valid_d;
      buf0_q          <= buf0_d;
      buf1_q          <= buf1_d;
      valid0_q        <= valid0_d;
      valid1_q        <= valid1_d;
    end
  end

  assign m_axis_tvalid    = valid0_q;
  assign m_axis_tdata     = buf0_q[AXIS_DATA_WIDTH-1:0];
  assign m_axis_tkeep     = buf0_q[AXIS_DATA_WIDTH +: AXIS_KEEP_WIDTH];
  assign m_axis_tlast     = buf0_q[BEAT_W-1];
  assign status_depth     = depth_q;
  assign status_pkt_count = pkt_count_q;
  assign status_drop      = drop_q;

endmodule

// File: tb/tb_sched_packet_fifo.sv
// Bench for sched_packet_fifo with a 16-beat FIFO: table-driven packet rows
// for the fill/drop boundaries, hand sequences for latency, throughput, random
// backpressure and reset, with a scoreboard queue checking every output beat.
module tb_sched_packet_fifo;

  localparam int DW    = 64;
  localparam int KW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [AW:0]   status_depth;
  logic [AW:0]   status_pkt_count;
  logic          status_drop;

  sched_packet_fifo #(
    .AXIS_DATA_WIDTH (DW),
    .AXIS_KEEP_WIDTH (KW),
    .DEPTH           (DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tkeep     (s_axis_tkeep),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tlast     (s_axis_tlast),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tkeep     (m_axis_tkeep),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .status_depth     (status_depth),
    .status_pkt_count (status_pkt_count),
    .status_drop      (status_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  // One packet per row: output ready level, length, expected drop pulses,
  // and expected packet count / depth once the row has settled.
  typedef struct {
    bit ready;
    int len;
    int exp_drops;
    int exp_pkts;
    int exp_depth;
  } vec_t;

  vec_t  vecs[9];
  beat_t sb_q[$];
  beat_t held;
  int    checks = 0;
  int    fails = 0;
  int    rx_count = 0;
  int    drop_seen = 0;
  int    cyc = 0;
  int    prev_cyc = 0;
  int    gaps = 0;
  bit    gap_track = 1'b0;
  bit    have_prev = 1'b0;
  bit    rand_ready = 1'b0;
  bit    stall_prev = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Runs on every falling edge: hold checks, random ready, scoreboard pops.
  task automatic monitorStep();
    beat_t exp_b;
    cyc++;
    if (stall_prev) begin
      checkOutput("hold_valid", 64'(m_axis_tvalid), 64'd1);
      checkOutput("hold_data", m_axis_tdata, held.data);
      checkOutput("hold_keep", 64'(m_axis_tkeep), 64'(held.keep));
      checkOutput("hold_last", 64'(m_axis_tlast), 64'(held.last));
    end
    if (rand_ready) m_axis_tready = ($urandom_range(0, 1) == 1);
    if (status_drop === 1'b1) drop_seen++;
    if (!rst && m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
      rx_count++;
      if (gap_track) begin
        if (have_prev && cyc != prev_cyc + 1) gaps++;
        prev_cyc  = cyc;
        have_prev = 1'b1;
      end
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_beat", 64'(m_axis_tdata), 64'd0);
      end else begin
        exp_b = sb_q.pop_front();
        checkOutput("beat_data", m_axis_tdata, exp_b.data);
        checkOutput("beat_keep", 64'(m_axis_tkeep), 64'(exp_b.keep));
        checkOutput("beat_last", 64'(m_axis_tlast), 64'(exp_b.last));
      end
    end
    if (rst) stall_prev = 1'b0;
    else stall_prev = (m_axis_tvalid === 1'b1) && (m_axis_tready !== 1'b1);
    held.data = m_axis_tdata;
    held.keep = m_axis_tkeep;
    held.last = m_axis_tlast;
  endtask

  // Drive one packet back-to-back; beats expected to survive go to the scoreboard.
  task automatic applyStimulus(input int len, input bit expect_kept);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = {$urandom, $urandom};
      b.keep = KW'($urandom);
      b.last = (i == len - 1);
      if (expect_kept) sb_q.push_back(b);
      s_axis_tdata  = b.data;
      s_axis_tkeep  = b.keep;
      s_axis_tlast  = b.last;
      s_axis_tvalid = 1'b1;
      tick(1);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic waitDrain(input int max_cycles, input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < max_cycles) begin
      tick(1);
      n++;
    end
    checkOutput(name, 64'(sb_q.size()), 64'd0);
    tick(2);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_s_tready"}, 64'(s_axis_tready), 64'd0);
    checkOutput({tag, "_m_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    checkOutput({tag, "_m_tlast"}, 64'(m_axis_tlast), 64'd0);
    checkOutput({tag, "_m_tdata"}, m_axis_tdata, 64'd0);
    checkOutput({tag, "_m_tkeep"}, 64'(m_axis_tkeep), 64'd0);
    checkOutput({tag, "_depth"}, 64'(status_depth), 64'd0);
    checkOutput({tag, "_pkts"}, 64'(status_pkt_count), 64'd0);
    checkOutput({tag, "_drop"}, 64'(status_drop), 64'd0);
  endtask

  task automatic runRows(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) begin
      m_axis_tready = vecs[r].ready;
      drop_seen = 0;
      applyStimulus(vecs[r].len, vecs[r].exp_drops == 0);
      tick(8);
      checkOutput($sformatf("row%0d_drops", r), 64'(drop_seen), 64'(vecs[r].exp_drops));
      checkOutput($sformatf("row%0d_pkts", r), 64'(status_pkt_count), 64'(vecs[r].exp_pkts));
      checkOutput($sformatf("row%0d_depth", r), 64'(status_depth), 64'(vecs[r].exp_depth));
    end
  endtask

  initial begin
    int rx0;
    int sent;
    int waited;
    int len;

    vecs[0] = '{1'b0, 6, 0, 1, 6};
    vecs[1] = '{1'b0, 6, 0, 2, 12};
    vecs[2] = '{1'b0, 6, 1, 2, 12};
    vecs[3] = '{1'b0, 5, 1, 2, 12};
    vecs[4] = '{1'b1, 20, 1, 0, 0};
    vecs[5] = '{1'b1, 3, 0, 0, 0};
    vecs[6] = '{1'b1, 1, 0, 0, 0};
    vecs[7] = '{1'b0, 16, 0, 1, 16};
    vecs[8] = '{1'b0, 1, 1, 1, 16};

    rst           = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;

    fork
      forever begin
        @(negedge clk);
        monitorStep();
      end
    join_none

    tick(3);
    checkResetValues("reset");
    rst = 1'b0;
    tick(1);
    checkOutput("tready_after_reset", 64'(s_axis_tready), 64'd1);

    // Single 4-beat packet: no output before tlast, valid two edges after it.
    $display("[TB] single 4-beat packet");
    m_axis_tready = 1'b1;
    rx0 = rx_count;
    applyStimulus(4, 1'b1);
    checkOutput("p1_pkts_after_commit", 64'(status_pkt_count), 64'd1);
    checkOutput("p1_valid_n1", 64'(m_axis_tvalid), 64'd0);
    tick(1);
    checkOutput("p1_valid_n1b", 64'(m_axis_tvalid), 64'd0);
    tick(1);
    checkOutput("p1_valid_n2", 64'(m_axis_tvalid), 64'd1);
    tick(4);
    checkOutput("p1_rx_beats", 64'(rx_count - rx0), 64'd4);
    checkOutput("p1_pkts_final", 64'(status_pkt_count), 64'd0);
    checkOutput("p1_depth_final", 64'(status_depth), 64'd0);

    // 100 back-to-back single-beat packets at full throughput.
    $display("[TB] back-to-back single-beat packets");
    rx0 = rx_count;
    drop_seen = 0;
    gaps = 0;
    have_prev = 1'b0;
    gap_track = 1'b1;
    for (int i = 0; i < 100; i++) applyStimulus(1, 1'b1);
    waitDrain(20, "b2b_drain");
    gap_track = 1'b0;
    checkOutput("b2b_rx_beats", 64'(rx_count - rx0), 64'd100);
    checkOutput("b2b_gaps", 64'(gaps), 64'd0);
    checkOutput("b2b_drops", 64'(drop_seen), 64'd0);

    // Fill with output stalled: two packets fit, overflow and full-on-tlast drop.
    $display("[TB] fill and overflow table");
    runRows(0, 3);
    rx0 = rx_count;
    m_axis_tready = 1'b1;
    waitDrain(40, "fill_drain");
    checkOutput("fill_rx_beats", 64'(rx_count - rx0), 64'd12);
    checkOutput("fill_pkts_final", 64'(status_pkt_count), 64'd0);

    // Oversized packet dropped, following packets intact; then exact fit.
    $display("[TB] oversize and exact-fit table");
    runRows(4, 8);
    rx0 = rx_count;
    m_axis_tready = 1'b1;
    waitDrain(40, "exact_drain");
    checkOutput("exact_rx_beats", 64'(rx_count - rx0), 64'd16);
    checkOutput("exact_depth_final", 64'(status_depth), 64'd0);

    // Random packets under 50% output ready, paced so nothing overflows.
    $display("[TB] random traffic");
    rx0 = rx_count;
    sent = 0;
    drop_seen = 0;
    rand_ready = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      len = $urandom_range(1, 4);
      waited = 0;
      while (sent - (rx_count - rx0) + len > DEPTH && waited < 200) begin
        tick(1);
        waited++;
      end
      if (waited >= 200) begin
        checkOutput("rand_room_timeout", 64'(waited), 64'd0);
        break;
      end
      tick($urandom_range(0, 2));
      applyStimulus(len, 1'b1);
      sent += len;
    end
    waitDrain(400, "rand_drain");
    rand_ready = 1'b0;
    m_axis_tready = 1'b1;
    tick(2);
    checkOutput("rand_rx_beats", 64'(rx_count - rx0), 64'(sent));
    checkOutput("rand_drops", 64'(drop_seen), 64'd0);

    // Reset mid-packet with two packets stored.
    $display("[TB] reset mid-packet");
    m_axis_tready = 1'b0;
    applyStimulus(3, 1'b1);
    applyStimulus(2, 1'b1);
    tick(4);
    checkOutput("rst_pre_pkts", 64'(status_pkt_count), 64'd2);
    s_axis_tdata  = {$urandom, $urandom};
    s_axis_tkeep  = KW'($urandom);
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    tick(2);
    s_axis_tvalid = 1'b0;
    rst = 1'b1;
    tick(1);
    checkResetValues("midrst");
    sb_q.delete();
    rst = 1'b0;
    tick(1);
    checkOutput("midrst_tready_release", 64'(s_axis_tready), 64'd1);
    m_axis_tready = 1'b1;
    applyStimulus(3, 1'b1);
    applyStimulus(1, 1'b1);
    waitDrain(30, "post_rst_drain");
    checkOutput("post_rst_pkts", 64'(status_pkt_count), 64'd0);
    checkOutput("post_rst_depth", 64'(status_depth), 64'd0);

    checkOutput("sb_empty_end", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
